// File: rtl/twiddle_cos_table_pkg.sv
// fft_pkg: shared twiddle-table types and default geometry.
package fft_pkg;
  localparam int FFT_N_DEFAULT  = 10;
  localparam int FFT_DW_DEFAULT = 16;
  localparam int TBL_AW         = FFT_N_DEFAULT - 2;
  localparam int TBL_DEPTH      = 2 ** TBL_AW;
  typedef enum logic [1:0] {IDLE, LOAD, READY} tbl_state_e;
endpackage

// File: rtl/twiddle_cos_table_if.sv
// twiddle_cos_table_if: read port and host load stream of the quarter-wave cosine table.
interface twiddle_cos_table_if #(
  parameter int FFT_N  = fft_pkg::FFT_N_DEFAULT,
  parameter int FFT_DW = fft_pkg::FFT_DW_DEFAULT
);
  logic              twact;
  logic [FFT_N-3:0]  twa;
  logic [FFT_DW-1:0] twdr_cos;
  logic              ld_start;
  logic              ld_valid;
  logic [FFT_DW-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              table_ready;
  logic              rd_err;
  logic              rd_err_clr;
  modport master (
    output twact, twa, ld_start, ld_valid, ld_data, rd_err_clr,
    input  twdr_cos, ld_ready, ld_done, table_ready, rd_err
  );
  modport slave (
    input  twact, twa, ld_start, ld_valid, ld_data, rd_err_clr,
    output twdr_cos, ld_ready, ld_done, table_ready, rd_err
  );
endinterface

// File: rtl/twiddle_cos_table_ram.sv
// twiddle_tbl_ram: simple dual-port table RAM, one write port, one registered synchronous read port.
module twiddle_tbl_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/twiddle_cos_table.sv
// twiddle_cos_table: run-time loaded quarter-wave cosine ROM with 1-cycle read latency and load FSM.
module twiddle_cos_table
  import fft_pkg::*;
#(
  parameter int FFT_N  = FFT_N_DEFAULT,
  parameter int FFT_DW = FFT_DW_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  twiddle_cos_table_if.slave  tw
);
  localparam int AW = FFT_N - 2;
  tbl_state_e        state;
  logic [AW-1:0]     wr_ptr;
  logic              rd_zero;
  logic [FFT_DW-1:0] ram_q;
  logic              we;
  assign we = (state == LOAD) && tw.ld_valid && !tw.ld_start;
  twiddle_tbl_ram #(.AW(AW), .DW(FFT_DW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (tw.ld_data),
    .re    (tw.twact),
    .raddr (tw.twa),
    .q     (ram_q)
  );
  // rd_zero remembers whether the last accepted read was gated, so the held output stays 0 too
  assign tw.twdr_cos = rd_zero ? '0 : ram_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_zero        <= 1'b1;
      tw.ld_ready    <= 1'b0;
      tw.ld_done     <= 1'b0;
      tw.table_ready <= 1'b0;
      tw.rd_err      <= 1'b0;
    end else begin
      tw.ld_done <= 1'b0;
      tw.rd_err  <= tw.rd_err_clr ? 1'b0 : (tw.rd_err | (tw.twact & ~tw.table_ready));
      if (tw.twact) rd_zero <= ~tw.table_ready;
      if (tw.ld_start) begin
        state          <= LOAD;
        wr_ptr         <= '0;
        tw.ld_ready    <= 1'b1;
        tw.table_ready <= 1'b0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == '1) begin
          state          <= READY;
          tw.ld_ready    <= 1'b0;
          tw.table_ready <= 1'b1;
          tw.ld_done     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_twiddle_cos_table.sv
// tb_twiddle_cos_table: directed and randomized checks of load/read behaviour against a table model.
module tb_twiddle_cos_table;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [15:0] mem [256];
  bit loading, ready, m_done, m_err;
  logic [15:0] m_q;
  int count;
  always #5 clk = ~clk;
  twiddle_cos_table_if #(.FFT_N(10), .FFT_DW(16)) tw ();
  twiddle_cos_table #(.FFT_N(10), .FFT_DW(16)) dut (.clk(clk), .rst_n(rst_n), .tw(tw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("twdr_cos", 32'(tw.twdr_cos), 32'(m_q));
    chk("ld_ready", 32'(tw.ld_ready), 32'(loading));
    chk("ld_done", 32'(tw.ld_done), 32'(m_done));
    chk("table_ready", 32'(tw.table_ready), 32'(ready));
    chk("rd_err", 32'(tw.rd_err), 32'(m_err));
  endtask

  task automatic model_reset();
    loading = 0; ready = 0; m_done = 0; m_err = 0; m_q = '0; count = 0;
  endtask

  task automatic idle_in();
    tw.twact = 0; tw.twa = '0; tw.ld_start = 0; tw.ld_valid = 0; tw.ld_data = '0; tw.rd_err_clr = 0;
  endtask

  // Advance one clock: model consumes the inputs presented before the edge, DUT is checked after it.
  task automatic step();
    if (tw.twact) m_q = ready ? mem[tw.twa] : 16'h0;
    m_err = tw.rd_err_clr ? 1'b0 : (m_err | (tw.twact && !ready));
    m_done = 0;
    if (tw.ld_start) begin
      loading = 1; ready = 0; count = 0;
    end else if (loading && tw.ld_valid) begin
      mem[count] = tw.ld_data;
      count++;
      if (count == 256) begin loading = 0; ready = 1; m_done = 1; end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load_words(input int n, input bit fixed, input logic [15:0] val);
    tw.ld_valid = 1;
    for (int k = 0; k < n; k++) begin
      tw.ld_data = fixed ? val : 16'(k * 3);
      step();
    end
    tw.ld_valid = 0;
  endtask

  initial begin
    int ra [4];
    int rexp [4];
    int done_cnt;
    int cyc;
    ra = '{1, 255, 0, 128};
    rexp = '{3, 765, 0, 384};
    idle_in();
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // read before load
    tw.twact = 1; tw.twa = 8'd7;
    step();
    chk("pre_load_data", 32'(tw.twdr_cos), 32'h0);
    chk("pre_load_err", 32'(tw.rd_err), 32'h1);
    tw.rd_err_clr = 1;
    step();
    chk("err_clr_priority", 32'(tw.rd_err), 32'h0);
    idle_in();
    step();

    // ramp load
    tw.ld_start = 1;
    step();
    tw.ld_start = 0;
    load_words(255, 0, 16'h0);
    chk("no_early_done", 32'(tw.ld_done), 32'h0);
    tw.ld_valid = 1; tw.ld_data = 16'(255 * 3);
    step();
    tw.ld_valid = 0;
    chk("ramp_done", 32'(tw.ld_done), 32'h1);
    chk("ramp_ready", 32'(tw.table_ready), 32'h1);
    tw.twact = 1; tw.twa = 8'd5;
    step();
    chk("ramp_rd5", 32'(tw.twdr_cos), 32'd15);
    chk("done_single", 32'(tw.ld_done), 32'h0);

    // back-to-back reads
    for (int i = 0; i < 4; i++) begin
      tw.twa = 8'(ra[i]);
      step();
      chk("b2b_rd", 32'(tw.twdr_cos), 32'(rexp[i]));
    end
    tw.twact = 0; tw.twa = 8'd9;
    step();
    chk("hold", 32'(tw.twdr_cos), 32'd384);

    // random reads of the ramp table
    for (int i = 0; i < 40; i++) begin
      tw.twact = 1'($urandom); tw.twa = 8'($urandom);
      step();
    end
    tw.twact = 0;

    // restart mid-load; coincident word must be dropped
    tw.ld_start = 1;
    step();
    tw.ld_start = 0;
    load_words(100, 1, 16'hAAAA);
    tw.ld_start = 1; tw.ld_valid = 1; tw.ld_data = 16'hBEEF;
    step();
    tw.ld_start = 0;
    done_cnt = 0;
    tw.ld_valid = 1; tw.ld_data = 16'h1234;
    for (int k = 0; k < 256; k++) begin
      step();
      if (tw.ld_done) done_cnt++;
    end
    tw.ld_valid = 0;
    chk("restart_done_cnt", 32'(done_cnt), 32'h1);
    tw.twact = 1;
    for (int a = 0; a < 256; a++) begin
      tw.twa = 8'(a);
      step();
      chk("restart_rd", 32'(tw.twdr_cos), 32'h1234);
    end
    tw.twact = 0;

    // bursty load with random reads interleaved
    tw.ld_start = 1;
    step();
    tw.ld_start = 0;
    done_cnt = 0;
    cyc = 0;
    while (loading && cyc < 2000) begin
      tw.ld_valid = 1'($urandom);
      tw.ld_data = 16'($urandom);
      tw.twact = 1'($urandom); tw.twa = 8'($urandom);
      tw.rd_err_clr = ($urandom_range(0, 7) == 0);
      step();
      if (tw.ld_done) done_cnt++;
      cyc++;
    end
    idle_in();
    chk("bursty_timeout", 32'(cyc < 2000), 32'h1);
    chk("bursty_writes", 32'(count), 32'd256);
    chk("bursty_done_cnt", 32'(done_cnt), 32'h1);
    step();
    for (int i = 0; i < 40; i++) begin
      tw.twact = 1; tw.twa = 8'($urandom);
      step();
    end
    idle_in();

    // async reset in the middle of a load
    tw.ld_start = 1;
    step();
    tw.ld_start = 0;
    load_words(50, 1, 16'h5555);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_twdr", 32'(tw.twdr_cos), 32'h0);
    chk("arst_ready", 32'(tw.ld_ready), 32'h0);
    chk("arst_tready", 32'(tw.table_ready), 32'h0);
    chk("arst_done", 32'(tw.ld_done), 32'h0);
    chk("arst_err", 32'(tw.rd_err), 32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tw.twact = 1; tw.twa = 8'($urandom);
      step();
      chk("post_rst_rd", 32'(tw.twdr_cos), 32'h0);
    end
    tw.twact = 0; tw.rd_err_clr = 1;
    step();
    tw.rd_err_clr = 0; tw.ld_start = 1;
    step();
    tw.ld_start = 0;
    load_words(256, 0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      tw.twact = 1; tw.twa = 8'($urandom);
      step();
    end
    idle_in();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
